// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_arb_pkg: shared FSM encoding and default sizes for reg_write_arbiter.
// Revision 1.0
// ---------------------------------------------------------------------------
package reg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    localparam int DEF_N    = 8;
    localparam int DEF_NREQ = 4;
    localparam int DEF_AW   = 2;

endpackage
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick: combinational rotating-priority encoder, search starts at ptr.
// Revision 1.0
// ---------------------------------------------------------------------------
import reg_arb_pkg::*;

module rr_pick #(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   winner
);

    logic found;
    int   idx;

    always_comb begin
        valid  = |req;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                winner = PW'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_write_arbiter: round-robin arbiter sharing one register bank write port.
// Revision 1.0
// ---------------------------------------------------------------------------
import reg_arb_pkg::*;

module reg_write_arbiter #(
    parameter int N    = DEF_N,
    parameter int NREQ = DEF_NREQ,
    parameter int AW   = DEF_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*N-1:0]    req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [(2**AW)-1:0]   load,
    output logic [N-1:0]         din,
    output logic                 busy
);

    localparam int PW   = $clog2(NREQ);
    localparam int NREG = 2**AW;

    arb_state_t      state, state_nx;
    logic [PW-1:0]   ptr, ptr_nx;
    logic [PW-1:0]   win, win_nx;
    logic [AW-1:0]   addr_q, addr_nx;
    logic [N-1:0]    data_q, data_nx;
    logic [NREQ-1:0] gnt_nx;
    logic [NREG-1:0] load_nx;
    logic            busy_nx;
    logic            pick_valid;
    logic [PW-1:0]   pick;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick)
    );

    // The shared bus simply presents the latched data; it holds through GAP/IDLE.
    assign din = data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        win_nx   = win;
        addr_nx  = addr_q;
        data_nx  = data_q;
        gnt_nx   = '0;
        load_nx  = '0;
        busy_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nx         = ST_LOAD;
                    win_nx           = pick;
                    addr_nx          = req_addr[int'(pick)*AW +: AW];
                    data_nx          = req_data[int'(pick)*N +: N];
                    gnt_nx[pick]     = 1'b1;
                    load_nx[addr_nx] = 1'b1;
                    busy_nx          = 1'b1;
                end
            end
            ST_LOAD: begin
                state_nx = ST_GAP;
                ptr_nx   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                busy_nx  = 1'b1;
            end
            ST_GAP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered so nothing on the outputs follows req combinationally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr    <= '0;
            win    <= '0;
            addr_q <= '0;
            data_q <= '0;
            gnt    <= '0;
            load   <= '0;
            busy   <= 1'b0;
        end else begin
            ptr    <= ptr_nx;
            win    <= win_nx;
            addr_q <= addr_nx;
            data_q <= data_nx;
            gnt    <= gnt_nx;
            load   <= load_nx;
            busy   <= busy_nx;
        end
    end

endmodule
`default_nettype wire
